adder_result_display: RTL and testbench

//  Downstream stage of the 4-bit ripple-carry adder datapath on the Basys3 board.

---
 rtl/adder_result_display.sv | 139 +++++++++++++
 tb/tb_adder_result_display.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_display.sv
// Captures the 5-bit ripple-carry adder result on a button edge and shows it
// as two decimal digits on the Basys3 multiplexed seven-segment display.
module adder_result_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sum_in,
    input  logic       carry_bit,
    input  logic       capture,
    output logic       result_valid,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    typedef enum logic [1:0] {
        DIG_ONES = 2'd0,
        DIG_TENS = 2'd1,
        DIG_OFF2 = 2'd2,
        DIG_OFF3 = 2'd3
    } digit_e;

    localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic                    prev_q, prev_d;
    logic [4:0]              result_q, result_d;
    logic                    valid_q, valid_d;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              an_q, an_d;

    logic                    cap_edge;
    logic [1:0]              tens;
    logic [3:0]              ones;
    digit_e                  sel;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Capture path: two-flop synchronizer followed by rising-edge detect.
    always_comb begin
        sync1_d  = capture;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        cap_edge = sync2_q & ~prev_q;
        result_d = result_q;
        valid_d  = valid_q;
        if (cap_edge) begin
            result_d = {carry_bit, sum_in};
            valid_d  = 1'b1;
        end
        cnt_d = cnt_q + CNT_ONE;
    end

    // Binary to two decimal digits by range compare and subtract.
    always_comb begin
        if (result_q >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(result_q - 5'd30);
        end else if (result_q >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(result_q - 5'd20);
        end else if (result_q >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(result_q - 5'd10);
        end else begin
            tens = 2'd0;
            ones = result_q[3:0];
        end
    end

    always_comb begin
        sel   = digit_e'(cnt_q[REFRESH_BITS-1 -: 2]);
        seg_d = SEG_BLANK;
        an_d  = 4'b1111;
        case (sel)
            DIG_ONES: begin
                an_d  = 4'b1110;
                seg_d = valid_q ? glyph(ones) : SEG_DASH;
            end
            DIG_TENS: begin
                // Leading zero on the tens digit is left dark once a value exists.
                if (!(valid_q && tens == 2'd0)) begin
                    an_d  = 4'b1101;
                    seg_d = valid_q ? glyph({2'b00, tens}) : SEG_DASH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            seg_q    <= '1;
            an_q     <= '1;
        end else begin
            cnt_q    <= cnt_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign result_valid = valid_q;
    assign seg          = seg_q;
    assign an           = an_q;
    assign dp           = 1'b1;

endmodule

// File: tb/tb_adder_result_display.sv
// Self-checking bench for adder_result_display with a 4-bit scan counter:
// directed vector table, hand-written corner sequences and random captures.
module tb_adder_result_display;

    localparam int RB      = 4;
    localparam int PERIOD  = 1 << RB;
    localparam int DIGLEN  = PERIOD / 4;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sum_in = 4'h0;
    logic       carry_bit = 1'b0;
    logic       capture = 1'b0;
    logic       result_valid;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int vectors = 0;
    int miscompares = 0;

    adder_result_display #(.REFRESH_BITS(RB)) dut (
        .clk          (clk),
        .rst          (rst),
        .sum_in       (sum_in),
        .carry_bit    (carry_bit),
        .capture      (capture),
        .result_valid (result_valid),
        .seg          (seg),
        .an           (an),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    logic [6:0] GLYPH [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model: capture level sampled each edge; a result is taken on the
    // third edge after a low-to-high transition of those samples.
    int         mcnt;
    int         mres;
    logic       mvalid;
    logic       h1, h2, h3;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;

    function automatic logic [10:0] model_out(input int cnt, input int res, input logic vld);
        int sel;
        int tens;
        int ones;
        sel  = (cnt / DIGLEN) % 4;
        tens = res / 10;
        ones = res % 10;
        if (sel == 0)
            return {4'b1110, vld ? GLYPH[ones] : DASH};
        if (sel == 1 && !(vld && tens == 0))
            return {4'b1101, vld ? GLYPH[tens] : DASH};
        return {4'b1111, BLANK};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt    <= 0;
            mres    <= 0;
            mvalid  <= 1'b0;
            h1      <= 1'b0;
            h2      <= 1'b0;
            h3      <= 1'b0;
            exp_an  <= 4'b1111;
            exp_seg <= BLANK;
        end else begin
            {exp_an, exp_seg} <= model_out(mcnt, mres, mvalid);
            if (h2 && !h3) begin
                mres   <= int'({carry_bit, sum_in});
                mvalid <= 1'b1;
            end
            h3   <= h2;
            h2   <= h1;
            h1   <= capture;
            mcnt <= (mcnt + 1) % PERIOD;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_an", 32'(an), 32'(exp_an));
        chk("model_seg", 32'(seg), 32'(exp_seg));
        chk("model_valid", 32'(result_valid), 32'(mvalid));
        chk("dp_off", 32'(dp), 32'd1);
    end

    task automatic do_capture(input logic [4:0] v, input int hold);
        @(negedge clk);
        {carry_bit, sum_in} = v;
        capture = 1'b1;
        repeat (hold) @(negedge clk);
        capture = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_display(input string nm, input logic [6:0] os, input logic [6:0] ts,
                                 input logic ton, input logic ev);
        int seen_o;
        int seen_t;
        seen_o = 0;
        seen_t = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            chk({nm, "_valid"}, 32'(result_valid), 32'(ev));
            if (an == 4'b1110) begin
                seen_o++;
                chk({nm, "_ones_seg"}, 32'(seg), 32'(os));
            end else if (an == 4'b1101) begin
                seen_t++;
                chk({nm, "_tens_seg"}, 32'(seg), 32'(ts));
            end else begin
                chk({nm, "_dark_seg"}, 32'(seg), 32'(BLANK));
            end
        end
        chk({nm, "_ones_shown"}, 32'(seen_o == DIGLEN), 32'd1);
        chk({nm, "_tens_shown"}, 32'(seen_t == DIGLEN), 32'(ton));
    endtask

    typedef struct {
        logic [4:0] val;
        logic [6:0] ones_seg;
        logic [6:0] tens_seg;
        logic       tens_on;
    } vec_t;

    vec_t tbl [0:9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{5'd27, 7'b1111000, 7'b0100100, 1'b1};
        tbl[1] = '{5'd5,  7'b0010010, BLANK,      1'b0};
        tbl[2] = '{5'd15, 7'b0010010, 7'b1111001, 1'b1};
        tbl[3] = '{5'd31, 7'b1111001, 7'b0110000, 1'b1};
        tbl[4] = '{5'd0,  7'b1000000, BLANK,      1'b0};
        tbl[5] = '{5'd10, 7'b1000000, 7'b1111001, 1'b1};
        tbl[6] = '{5'd19, 7'b0010000, 7'b1111001, 1'b1};
        tbl[7] = '{5'd26, 7'b0000010, 7'b0100100, 1'b1};
        tbl[8] = '{5'd8,  7'b0000000, BLANK,      1'b0};
        tbl[9] = '{5'd23, 7'b0110000, 7'b0100100, 1'b1};

        // Reset state and dashes before any capture
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'(BLANK));
        chk("rst_valid", 32'(result_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_an", 32'(an), 32'hF);
        chk("rel_seg", 32'(seg), 32'(BLANK));
        check_display("dashes", DASH, DASH, 1'b1, 1'b0);

        // 27: valid appears on the third edge after the rise
        @(negedge clk);
        sum_in = 4'hB;
        carry_bit = 1'b1;
        capture = 1'b1;
        @(negedge clk);
        chk("lat_edge1", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge2", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge3", 32'(result_valid), 32'd1);
        capture = 1'b0;
        @(negedge clk);
        check_display("r27", tbl[0].ones_seg, tbl[0].tens_seg, tbl[0].tens_on, 1'b1);

        do_capture(5'h05, 2);
        check_display("r5", tbl[1].ones_seg, tbl[1].tens_seg, tbl[1].tens_on, 1'b1);

        // Held capture: input changes must not recapture
        @(negedge clk);
        capture = 1'b1;
        repeat (4) @(negedge clk);
        sum_in = 4'h0;
        repeat (4) @(negedge clk);
        sum_in = 4'hF;
        check_display("hold5", tbl[1].ones_seg, tbl[1].tens_seg, tbl[1].tens_on, 1'b1);
        capture = 1'b0;
        repeat (2) @(negedge clk);
        capture = 1'b1;
        repeat (3) @(negedge clk);
        capture = 1'b0;
        @(negedge clk);
        check_display("r15", tbl[2].ones_seg, tbl[2].tens_seg, tbl[2].tens_on, 1'b1);

        for (int i = 0; i < 10; i++) begin
            do_capture(tbl[i].val, 1 + (i % 3));
            check_display($sformatf("tbl%0d", i), tbl[i].ones_seg, tbl[i].tens_seg,
                          tbl[i].tens_on, 1'b1);
        end

        // Random captures with input churn while held
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            {carry_bit, sum_in} = 5'($urandom);
            capture = 1'b1;
            repeat ($urandom_range(1, 5)) begin
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) {carry_bit, sum_in} = 5'($urandom);
            end
            capture = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Reset one clock after a capture rise discards the pending edge
        @(negedge clk);
        chk("pre_rst_valid", 32'(result_valid), 32'd1);
        {carry_bit, sum_in} = 5'd9;
        capture = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'(BLANK));
        chk("async_valid", 32'(result_valid), 32'd0);
        capture = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_display("post_rst", DASH, DASH, 1'b1, 1'b0);
        repeat (PERIOD) @(negedge clk);
        chk("no_stale", 32'(result_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
